// File: rtl/tm1638_pkg.sv
// Shared constants, state encoding and byte-select helper for the TM1638 frame scheduler.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_WRITE_AI = 8'h40;
  localparam logic [7:0] CMD_ADDR_BASE     = 8'hC0;
  localparam logic [7:0] CMD_DISP_CTRL     = 8'h80;
  localparam int unsigned NUM_ADDR         = 16;

  typedef enum logic [2:0] {IDLE, STB_LOW, SEND, DRAIN, GAP} state_e;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] s;
    logic [7:0] t;
    logic [7:0] leds;
    logic [2:0] brightness;
    logic       display_on;
  } frame_cfg_t;

  // Index of the final byte in each STB-low segment (segment 1 carries 0xC0 plus NUM_ADDR bytes).
  function automatic logic [4:0] seg_last_idx(input logic [1:0] seg);
    return (seg == 2'd1) ? 5'(NUM_ADDR) : 5'd0;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [1:0] seg, input logic [4:0] idx,
                                            input frame_cfg_t cfg);
    logic [7:0] b;
    logic [3:0] addr;
    b    = 8'h00;
    addr = 4'(idx - 5'd1);
    case (seg)
      2'd0: b = CMD_DATA_WRITE_AI;
      2'd1: begin
        if (idx == 5'd0) begin
          b = CMD_ADDR_BASE;
        end else if (addr[0]) begin
          b = {7'b0, cfg.leds[addr[3:1]]};
        end else begin
          case (addr[3:1])
            3'd0:    b = cfg.f;
            3'd1:    b = cfg.s;
            3'd2:    b = cfg.t;
            default: b = 8'h00;
          endcase
        end
      end
      default: b = CMD_DISP_CTRL | {4'b0, cfg.display_on, cfg.brightness};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tm1638_frame_scheduler.sv
// Sequences one TM1638 refresh frame (data cmd, address cmd + 16 bytes, display control)
// as three STB-low windows, feeding bytes to the serializer over valid/ready.
module tm1638_frame_scheduler
  import tm1638_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 1_000_000,
  parameter int unsigned STB_GAP        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] F,
  input  logic [7:0] S,
  input  logic [7:0] T,
  input  logic [7:0] leds,
  input  logic [2:0] brightness,
  input  logic       display_on,
  input  logic       update_req,
  input  logic       tx_ready,
  input  logic       tx_idle,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       strobe,
  output logic       busy,
  output logic       frame_done
);

  localparam bit          RefreshEn   = (REFRESH_CYCLES != 0);
  localparam logic [31:0] RefreshLast = 32'(REFRESH_CYCLES - 1);
  localparam logic [31:0] GapLast     = (STB_GAP > 1) ? 32'(STB_GAP - 1) : 32'd0;

  state_e      state_q, state_d;
  logic [1:0]  seg_q, seg_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] refresh_q, refresh_d;
  logic        pending_q, pending_d;
  frame_cfg_t  cfg_q, cfg_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        start;

  always_comb begin
    state_d      = state_q;
    seg_d        = seg_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    refresh_d    = refresh_q;
    pending_d    = pending_q;
    cfg_d        = cfg_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    strobe_d     = strobe_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start        = 1'b0;

    // Requests outside IDLE collapse into a single pending frame.
    if (update_req && (state_q != IDLE)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        start = update_req || pending_q || (RefreshEn && (refresh_q == RefreshLast));
        if (start) begin
          state_d   = STB_LOW;
          strobe_d  = 1'b0;
          busy_d    = 1'b1;
          seg_d     = 2'd0;
          idx_d     = 5'd0;
          pending_d = 1'b0;
          refresh_d = 32'd0;
          cfg_d     = '{f: F, s: S, t: T, leds: leds, brightness: brightness,
                        display_on: display_on};
        end else if (refresh_q != RefreshLast) begin
          refresh_d = refresh_q + 32'd1;
        end
      end
      STB_LOW: begin
        state_d    = SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = frame_byte(seg_q, idx_q, cfg_q);
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == seg_last_idx(seg_q)) begin
            tx_valid_d = 1'b0;
            state_d    = DRAIN;
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_data_d = frame_byte(seg_q, idx_q + 5'd1, cfg_q);
          end
        end
      end
      DRAIN: begin
        if (tx_idle) begin
          strobe_d = 1'b1;
          gap_d    = 32'd0;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (gap_q == GapLast) begin
          if (seg_q != 2'd2) begin
            seg_d    = seg_q + 2'd1;
            idx_d    = 5'd0;
            strobe_d = 1'b0;
            state_d  = STB_LOW;
          end else begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      seg_q        <= 2'd0;
      idx_q        <= 5'd0;
      gap_q        <= 32'd0;
      refresh_q    <= 32'd0;
      pending_q    <= 1'b0;
      cfg_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      strobe_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      refresh_q    <= refresh_d;
      pending_q    <= pending_d;
      cfg_q        <= cfg_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign strobe     = strobe_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/tm1638_frame_scheduler.md
Name: tm1638_frame_scheduler

Overview:
- Sequences complete TM1638 display-refresh transactions.
- Builds the 19-byte command/data stream: data command, address command with 16 data bytes, display-control command.
- Drives STB and hands bytes one at a time to the existing byte serializer (clock/DIO shifter) over a valid/ready handshake.
- Sits between the 7-segment translators (F/S/T digit codes) and the TM1638 pins. Triggers on an explicit update request or on a periodic refresh timer.

Parameters:
- REFRESH_CYCLES, 1_000_000: clk cycles between automatic refresh frames (10 ms at 100 MHz); 0 disables auto refresh.
- STB_GAP, 4: minimum clk cycles STB is held high between command segments and after a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- F  in  8  segment code, digit position 0 (address 0x00)
- S  in  8  segment code, digit position 1 (address 0x02)
- T  in  8  segment code, digit position 2 (address 0x04)
- leds  in  8  LED i on when bit i set (address 2i+1)
- brightness  in  3  display-control pulse width
- display_on  in  1  display enable bit of control command
- update_req  in  1  single-cycle request for an immediate frame
- tx_ready  in  1  serializer can accept a byte
- tx_idle  in  1  serializer has finished shifting all accepted bytes
- tx_valid  out  1  tx_data holds a byte to send
- tx_data  out  8  byte to serializer, LSB shifted first by serializer
- strobe  out  1  TM1638 STB, active low
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, immediate, also mid-frame): strobe=1, tx_valid=0, tx_data=0x00, busy=0, frame_done=0, pending=0, refresh counter=0, state=IDLE.
- Byte transfer occurs on a cycle with tx_valid && tx_ready. While tx_valid=1 && tx_ready=0, tx_data is held stable.
- Frame start: F, S, T, leds, brightness, display_on are snapshotted. Later input changes do not affect the current frame.
- Segment 0: 0x40 (write, auto-increment).
- Segment 1: 0xC0, then 16 data bytes for addresses 0x00..0x0F.
  - Addr 0x00 = F, 0x02 = S, 0x04 = T.
  - Other even addresses = 0x00.
  - Odd addr 2i+1 = {7'b0, leds[i]}.
- Segment 2: 0x80 | (display_on<<3) | brightness.
- States:
  - IDLE: strobe=1. Go to STB_LOW when update_req=1, or pending=1, or refresh counter reaches REFRESH_CYCLES-1 (REFRESH_CYCLES≠0). On entry, seg=0, byte index=0, busy=1.
  - STB_LOW: strobe=0 for one cycle (setup); go to SEND.
  - SEND: tx_valid=1 with the current byte. On transfer, advance the index. After the last byte of the segment is transferred, tx_valid=0 next cycle; go to DRAIN.
  - DRAIN: strobe stays 0 until tx_idle=1, then strobe=1; go to GAP.
  - GAP: strobe=1 for STB_GAP cycles. Then, if seg<2: seg++, go to STB_LOW. Otherwise frame_done=1 for one cycle, busy=0, go to IDLE.
- Latency: with update_req high in IDLE at cycle N:
  - strobe=0 and busy=1 at N+1
  - tx_valid=1 and tx_data=0x40 at N+2
- Frame length: 19 bytes in total, in three STB-low windows.
- update_req while busy sets pending. Multiple requests collapse to one. pending clears at the next frame start; that frame starts from IDLE the cycle after frame_done.
- update_req in the same cycle as the refresh timer expiring starts exactly one frame.
- Refresh counter:
  - resets to 0 at every frame start;
  - counts only in IDLE;
  - saturates.
- frame_done and update_req in the same cycle: the request is recorded as pending and the next frame follows.
- tx_idle is ignored outside DRAIN.
- tx_ready stuck low holds SEND indefinitely. No timeout.

Decomposition:
- Shared package tm1638_pkg:
  - command constants CMD_DATA_WRITE_AI=0x40, CMD_ADDR_BASE=0xC0, CMD_DISP_CTRL=0x80
  - state enum (IDLE, STB_LOW, SEND, DRAIN, GAP)
  - NUM_ADDR=16
- No sub-module. The byte-select mux is a combinational function in the package. The serializer stays a separate existing block.

Test Plan:
- update_req pulse with F=0x3F, S=0x06, T=0x5B, leds=0x01, brightness=7, display_on=1, tx_ready=1, tx_idle pulsed after each segment:
  - byte stream is 0x40 | 0xC0,0x3F,0x01,0x06,0x00,0x5B,0x00×11 | 0x8F;
  - exactly 3 strobe-low windows;
  - frame_done once.
- tx_ready toggling 1-in-3 cycles: tx_data is stable while stalled, and the 19-byte stream is unchanged.
- Two update_req pulses during a busy frame: exactly one extra frame follows immediately. F changed mid-frame appears only in the second frame.
- REFRESH_CYCLES=50, no requests: a frame starts every 50 IDLE cycles.
- rst asserted during segment 1 byte 5:
  - strobe=1, tx_valid=0, busy=0 immediately (same cycle, asynchronously);
  - after release, IDLE; the next request produces a full frame.
- display_on=0, brightness=3: control byte is 0x83. tx_idle held low 20 cycles in DRAIN keeps strobe=0 for those cycles.
